// File: rtl/aer_event_arbiter.sv
// aer_event_arbiter
//   Captures single-cycle spike pulses from up to 16 channels, timestamps each with a
//   free-running counter, and round-robin arbitrates pending spikes onto a 24-bit AER
//   word {channel_id[3:0], timestamp[19:0]} under a valid/ready handshake.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   en         gates spike capture and timestamp counting
//   spike_in   per-channel spike pulses, sampled on each rising edge
//   aer_ready  downstream accepts the current AER word
//   aer_out    AER word {channel_id, timestamp}
//   aer_valid  aer_out holds a valid event
//   pending    per-channel pending flags
//   ovf_cnt    saturating count of dropped spikes
//   busy       any channel pending or a word in flight
module aer_event_arbiter #(
  parameter int unsigned N_CH  = 16,
  parameter int unsigned TS_W  = 20,
  parameter int unsigned OVF_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_CH-1:0]  spike_in,
  input  logic             aer_ready,
  output logic [TS_W+3:0]  aer_out,
  output logic             aer_valid,
  output logic [N_CH-1:0]  pending,
  output logic [OVF_W-1:0] ovf_cnt,
  output logic             busy
);

  // The FSM state bit doubles as aer_valid.
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSend = 1'b1;

  localparam int unsigned CntW = $clog2(N_CH + 1);

  logic [0:0]       state_q, state_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [3:0]       rr_q, rr_d;
  logic [N_CH-1:0]  pending_q, pending_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;
  logic [TS_W+3:0]  out_q, out_d;
  logic [TS_W-1:0]  ts_store_q [N_CH];

  logic             any_pend;
  logic             load_ok;
  logic             grant;
  logic             gnt_found;
  logic [3:0]       gnt_idx;
  logic [N_CH-1:0]  gnt_vec;
  logic [N_CH-1:0]  spike_en;
  logic [N_CH-1:0]  accept;
  logic [N_CH-1:0]  drop;
  logic [CntW-1:0]  drop_cnt;
  logic [OVF_W:0]   ovf_sum;

  assign any_pend = |pending_q;
  assign load_ok  = (state_q == StIdle) | aer_ready;
  assign grant    = load_ok & gnt_found;

  // First pending channel at or after rr, wrapping modulo N_CH.
  always_comb begin
    logic [4:0] idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      idx = {1'b0, rr_q} + 5'(k);
      if (idx >= 5'(N_CH)) idx = idx - 5'(N_CH);
      if (!gnt_found && pending_q[idx[3:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx[3:0];
      end
    end
  end

  always_comb begin
    gnt_vec = '0;
    if (grant) gnt_vec[gnt_idx] = 1'b1;
  end

  // A channel being granted this cycle may accept a fresh spike into its emptied slot.
  assign spike_en  = en ? spike_in : '0;
  assign accept    = spike_en & (~pending_q | gnt_vec);
  assign drop      = spike_en & pending_q & ~gnt_vec;
  assign pending_d = (pending_q & ~gnt_vec) | accept;

  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      drop_cnt = drop_cnt + CntW'(drop[i]);
    end
  end

  assign ovf_sum = {1'b0, ovf_q} + (OVF_W + 1)'(drop_cnt);
  assign ovf_d   = ovf_sum[OVF_W] ? {OVF_W{1'b1}} : ovf_sum[OVF_W-1:0];
  assign ts_d    = en ? ts_q + 1'b1 : ts_q;

  always_comb begin
    out_d = out_q;
    rr_d  = rr_q;
    if (grant) begin
      out_d = {gnt_idx, ts_store_q[gnt_idx]};
      rr_d  = (32'(gnt_idx) == N_CH - 1) ? 4'd0 : gnt_idx + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_pend) state_d = StSend;
      StSend:  if (aer_ready && !any_pend) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ts_q      <= '0;
      rr_q      <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      ts_q      <= ts_d;
      rr_q      <= rr_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      out_q     <= out_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_CH); i++) ts_store_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        if (accept[i]) ts_store_q[i] <= ts_q;
      end
    end
  end

  assign aer_out   = out_q;
  assign aer_valid = state_q;
  assign pending   = pending_q;
  assign ovf_cnt   = ovf_q;
  assign busy      = any_pend | state_q;

endmodule

// File: tb/tb_aer_event_arbiter.sv
// tb_aer_event_arbiter
//   Directed scenarios plus randomized traffic, every cycle compared against a
//   behavioural model of the arbiter built from per-channel arrays.
module tb_aer_event_arbiter;

  localparam int NCH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] spike_in = '0;
  logic        aer_ready = 1'b0;
  logic [23:0] aer_out;
  logic        aer_valid;
  logic [15:0] pending;
  logic [15:0] ovf_cnt;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit [15:0]   m_pend;
  logic [19:0] m_store [NCH];
  int unsigned m_ts;
  int          m_rr;
  bit          m_valid;
  logic [23:0] m_out;
  int unsigned m_ovf;

  aer_event_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .spike_in  (spike_in),
    .aer_ready (aer_ready),
    .aer_out   (aer_out),
    .aer_valid (aer_valid),
    .pending   (pending),
    .ovf_cnt   (ovf_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_ts    = 0;
    m_rr    = 0;
    m_valid = 1'b0;
    m_out   = '0;
    m_ovf   = 0;
    for (int i = 0; i < NCH; i++) m_store[i] = '0;
  endtask

  // One clock edge of the arbiter, written from the behavioural rules.
  task automatic model_step(input logic [15:0] spk, input bit e, input bit rdy);
    bit [15:0] old_p;
    int        g;
    int        c;
    old_p = m_pend;
    g     = -1;
    if (!m_valid || rdy) begin
      for (int k = 0; k < NCH; k++) begin
        c = (m_rr + k) % NCH;
        if (g < 0 && old_p[c]) g = c;
      end
      if (g >= 0) begin
        m_out     = {g[3:0], m_store[g]};
        m_valid   = 1'b1;
        m_pend[g] = 1'b0;
        m_rr      = (g + 1) % NCH;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (e) begin
      for (int i = 0; i < NCH; i++) begin
        if (spk[i]) begin
          if (!old_p[i] || i == g) begin
            m_pend[i]  = 1'b1;
            m_store[i] = m_ts[19:0];
          end else if (m_ovf < 65535) begin
            m_ovf++;
          end
        end
      end
      m_ts = (m_ts + 1) & 32'hFFFFF;
    end
  endtask

  task automatic check_outputs();
    check("aer_valid", 32'(aer_valid), 32'(m_valid));
    check("aer_out",   32'(aer_out),   32'(m_out));
    check("pending",   32'(pending),   32'(m_pend));
    check("ovf_cnt",   32'(ovf_cnt),   m_ovf);
    check("busy",      32'(busy),      32'((m_pend != 0) || m_valid));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [15:0] spk, input bit e, input bit rdy);
    spike_in  = spk;
    en        = e;
    aer_ready = rdy;
    @(posedge clk);
    model_step(spk, e, rdy);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    spike_in  = '0;
    en        = 1'b0;
    aer_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs();
  endtask

  initial begin
    logic [15:0] spk;
    int          nword;
    @(negedge clk);

    // Single pulse on channel 5 at ts 0x10
    do_reset();
    for (int i = 0; i < 16; i++) step('0, 1'b1, 1'b1);
    step(16'h0020, 1'b1, 1'b1);
    check("t1_valid_lo", 32'(aer_valid), 32'd0);
    step('0, 1'b1, 1'b1);
    check("t1_valid_hi", 32'(aer_valid), 32'd1);
    check("t1_word", 32'(aer_out), 32'h500010);
    step('0, 1'b1, 1'b1);
    check("t1_one_cycle", 32'(aer_valid), 32'd0);

    // Channels 3, 7, 12 together at ts 0x20
    do_reset();
    for (int i = 0; i < 32; i++) step('0, 1'b1, 1'b1);
    step(16'h1088, 1'b1, 1'b1);
    step('0, 1'b1, 1'b1);
    check("t2_word0", 32'(aer_out), 32'h300020);
    step('0, 1'b1, 1'b1);
    check("t2_word1", 32'(aer_out), 32'h700020);
    step('0, 1'b1, 1'b1);
    check("t2_word2", 32'(aer_out), 32'hC00020);
    step('0, 1'b1, 1'b1);
    check("t2_drained", 32'(aer_valid), 32'd0);
    // rr is now 13: channel 14 must win over channel 12
    step(16'h5000, 1'b1, 1'b1);
    step('0, 1'b1, 1'b1);
    check("t2_rr13", 32'(aer_out[23:20]), 32'hE);

    // Backpressure on channel 2
    do_reset();
    step(16'h0004, 1'b1, 1'b0);
    step(16'h0004, 1'b1, 1'b0);
    step(16'h0004, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    step(16'h0004, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    check("t3_ovf", 32'(ovf_cnt), 32'd2);
    check("t3_held", 32'(aer_out), 32'h200000);
    step('0, 1'b1, 1'b1);
    check("t3_second_id", 32'(aer_out[23:20]), 32'h2);
    check("t3_second_valid", 32'(aer_valid), 32'd1);
    step('0, 1'b1, 1'b1);
    check("t3_single", 32'(aer_valid), 32'd0);

    // Timestamp wrap
    do_reset();
    force dut.ts_q = 20'hFFFFE;
    step('0, 1'b0, 1'b1);
    release dut.ts_q;
    m_ts = 32'hFFFFE;
    step('0, 1'b1, 1'b1);
    step(16'h0002, 1'b1, 1'b1);
    step('0, 1'b1, 1'b1);
    check("t4_pre_wrap", 32'(aer_out), 32'h1FFFFF);
    step(16'h0002, 1'b1, 1'b1);
    step('0, 1'b1, 1'b1);
    check("t4_post_wrap", 32'(aer_out), 32'h100001);

    // All channels every cycle: fairness and drop accounting
    do_reset();
    step(16'hFFFF, 1'b1, 1'b1);
    nword = 0;
    for (int i = 0; i < 32; i++) begin
      step(16'hFFFF, 1'b1, 1'b1);
      check("t5_id", 32'(aer_out[23:20]), 32'(nword % NCH));
      nword++;
    end
    check("t5_ovf", 32'(ovf_cnt), 32'd480);

    // Async reset mid-transfer
    do_reset();
    step(16'h001F, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(aer_valid), 32'd0);
    check("t6_out", 32'(aer_out), 32'd0);
    check("t6_pending", 32'(pending), 32'd0);
    check("t6_ovf", 32'(ovf_cnt), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step('0, 1'b1, 1'b1);
    check("t6_no_event", 32'(aer_valid), 32'd0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      spk = 16'($urandom & $urandom & $urandom);
      step(spk, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
    end

    // Overflow counter saturation
    do_reset();
    for (int i = 0; i < 4500; i++) step(16'hFFFF, 1'b1, 1'b0);
    check("ovf_saturated", 32'(ovf_cnt), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aer_event_arbiter.md
Name: aer_event_arbiter

Overview:
- Collects single-cycle spike pulses from up to 16 cochlear channels.
- Timestamps each spike with a free-running 20-bit counter.
- Round-robin arbitrates the pending spikes onto the single 24-bit AER bus {channel_id[3:0], timestamp[19:0]} with a valid/ready handshake.
- Sits upstream of the neural accelerator's AER input decoder and is the sole sequencer of that bus.

Parameters:
- N_CH, 16, number of spike channels; legal range 1..16 (channel id field is 4 bits).
- TS_W, 20, timestamp width; fixed at 20 to match the AER word.
- OVF_W, 16, width of the dropped-spike counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  enable: gates spike capture and timestamp counting.
- spike_in  input  N_CH  per-channel spike pulses, sampled each rising edge.
- aer_ready  input  1  downstream accepts the AER word this cycle.
- aer_out  output  24  AER word {channel_id[3:0], timestamp[19:0]}.
- aer_valid  output  1  aer_out holds a valid event.
- pending  output  N_CH  per-channel pending flags (status).
- ovf_cnt  output  OVF_W  count of dropped spikes, saturating.
- busy  output  1  high when any pending bit is set or aer_valid is high.

Behaviour:
- Reset (async, rst_n low) values:
  - aer_out = 0, aer_valid = 0, pending = 0, ovf_cnt = 0, busy = 0.
  - Timestamp counter ts = 0, round-robin pointer rr = 0, per-channel timestamp store = 0.
  - Reset mid-transfer discards all pending events and any in-flight word. No event is emitted after rst_n deasserts until new spikes arrive.
- Timestamp counter:
  - ts increments by 1 each cycle while en = 1; held while en = 0.
  - Wraps 0xFFFFF -> 0x00000 with no flag.
- Capture, per channel i, on each edge where en = 1 and spike_in[i] = 1:
  - If pending[i] = 0, or channel i is granted this same cycle: set pending[i] = 1 and store ts_store[i] = current ts (the pre-increment value).
  - Otherwise the spike is dropped: ts_store[i] is unchanged and ovf_cnt increments, saturating at 2^OVF_W-1.
  - Multiple channels dropping in one cycle add the number of drops, still saturating.
  - With en = 0, spike_in is ignored and pending continues to drain.
- Load condition: load_ok = (!aer_valid) | (aer_valid & aer_ready).
- Arbitration, evaluated on the registered pending vector:
  - When load_ok and pending != 0, the winner g is the first set bit searching from index rr upward, wrapping modulo N_CH.
  - On the edge: aer_out <= {g[3:0], ts_store[g]}, aer_valid <= 1, pending[g] cleared (unless re-set by the capture rule above), rr <= (g+1) mod N_CH.
  - When load_ok and pending == 0: aer_valid <= 0, aer_out holds its last value.
- Handshake:
  - While aer_valid & !aer_ready, aer_out and aer_valid are held stable; no grant occurs and rr is frozen.
  - A transfer completes on an edge where aer_valid & aer_ready.
- Latency and throughput:
  - A spike sampled at edge k sets pending at k. With an idle bus, aer_valid is high after edge k+1 (2-cycle spike-to-valid).
  - With aer_ready held high, one event is issued per cycle.
- Fairness: with all N_CH channels continuously pending, each channel is granted exactly once per N_CH grants.
- FSM (aer_valid is the state bit):
  - IDLE (aer_valid = 0): go to SEND on pending != 0.
  - SEND (aer_valid = 1): stay in SEND if aer_ready & pending != 0, or if !aer_ready; go to IDLE if aer_ready & pending == 0.
- busy = (|pending) | aer_valid, combinational from registers.

Test Plan:
- Reset, en=1, single pulse spike_in[5] when ts=0x00010, aer_ready=1 -> aer_valid high 2 cycles later for one cycle, aer_out=0x500010.
- Pulse channels 3, 7 and 12 in the same cycle (ts=0x00020), rr=0, aer_ready=1 -> three back-to-back words 0x300020, 0x700020, 0xC00020; rr ends at 13.
- Channel 2 pending with aer_ready held low 5 cycles while spike_in[2] pulses twice -> aer_out stable throughout, ovf_cnt=2, then a single 0x2xxxxx event after ready rises.
- Preload ts=0xFFFFE, spike ch 1 at 0xFFFFF and ch 1 again 2 cycles later (aer_ready=1) -> events 0x1FFFFF then 0x100001 (wrap passes through 0x00000).
- All 16 channels spiking every cycle, aer_ready=1 for 32 cycles -> channel ids cycle 0..15 twice in order, ovf_cnt increases by the count of dropped pulses, no channel starved.
- Assert rst_n low while aer_valid=1 with 4 channels pending -> all outputs 0 immediately (async), no event emitted after release until a new spike.
